// File: rtl/fab_pipe_reg_pkg.sv
// Shared definitions for the FAB execute-path pipeline register: bus widths,
// the per-stage command, lane slicing helpers and the issue-order compare.
package fab_pipe_reg_pkg;

  localparam int FAB_PC_W      = 32;
  localparam int FAB_CTRL_W    = 72;
  localparam int FAB_TAG_MAX_W = 8;

  // What every register stage does on the coming edge.
  typedef enum logic [1:0] {
    STG_LOAD  = 2'd0,
    STG_HOLD  = 2'd1,
    STG_FLUSH = 2'd2
  } stg_cmd_e;

  // Tag width for a given lane count; a single lane still carries one bit.
  function automatic int tag_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  // Bit offset of a lane's field inside a flat lane-packed bus.
  function automatic int lane_lsb(input int lane, input int field_w);
    return lane * field_w;
  endfunction

  // Smaller tag is older, so "younger" is a plain unsigned greater-than.
  function automatic logic tag_younger(input logic [FAB_TAG_MAX_W-1:0] num,
                                       input logic [FAB_TAG_MAX_W-1:0] br_num);
    return num > br_num;
  endfunction

  // Flush beats stall; reset is handled inside the stages themselves.
  function automatic stg_cmd_e stage_cmd(input logic flush, input logic stop);
    if (flush)     return STG_FLUSH;
    else if (stop) return STG_HOLD;
    else           return STG_LOAD;
  endfunction

endpackage

// File: rtl/fab_pipe_reg_stage.sv
// One LANES-wide register stage: per-lane valid plus pc/npc/ctrl/tag payload.
// Flush only drops the valids; payload is left as-is because consumers only
// look at payload on valid lanes.
module fab_pipe_stage
  import fab_pipe_reg_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int NUM_W  = 1,
  parameter int PC_W   = FAB_PC_W,
  parameter int CTRL_W = FAB_CTRL_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  stg_cmd_e                cmd,
  input  logic [LANES-1:0]        d_valid,
  input  logic [LANES*NUM_W-1:0]  d_num,
  input  logic [LANES*PC_W-1:0]   d_pc,
  input  logic [LANES*PC_W-1:0]   d_npc,
  input  logic [LANES*CTRL_W-1:0] d_ctrl,
  output logic [LANES-1:0]        q_valid,
  output logic [LANES*NUM_W-1:0]  q_num,
  output logic [LANES*PC_W-1:0]   q_pc,
  output logic [LANES*PC_W-1:0]   q_npc,
  output logic [LANES*CTRL_W-1:0] q_ctrl
);

  // Stage register: reset clears everything, otherwise load / hold / flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid <= '0;
      q_num   <= '0;
      q_pc    <= '0;
      q_npc   <= '0;
      q_ctrl  <= '0;
    end else begin
      unique case (cmd)
        STG_LOAD: begin
          q_valid <= d_valid;
          q_num   <= d_num;
          q_pc    <= d_pc;
          q_npc   <= d_npc;
          q_ctrl  <= d_ctrl;
        end
        STG_FLUSH: begin
          q_valid <= '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/fab_pipe_reg.sv
// Multi-lane pipeline register for the FAB execute path. DEPTH identical
// stages in a chain; stage0 input gets same-group wrong-path kill, and a
// saturating counter records cycles spent stalled with live output.
module fab_pipe_reg
  import fab_pipe_reg_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int DEPTH  = 1,
  parameter int PC_W   = FAB_PC_W,
  parameter int CTRL_W = FAB_CTRL_W,
  parameter int NUM_W  = tag_width(LANES),
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stop,
  input  logic                    flush,
  input  logic [LANES-1:0]        in_valid,
  input  logic [LANES*NUM_W-1:0]  in_num,
  input  logic [LANES*PC_W-1:0]   in_pc,
  input  logic [LANES*PC_W-1:0]   in_npc,
  input  logic [LANES*CTRL_W-1:0] in_ctrl,
  input  logic                    br_valid,
  input  logic [NUM_W-1:0]        br_num,
  output logic [LANES-1:0]        out_valid,
  output logic [LANES*NUM_W-1:0]  out_num,
  output logic [LANES*PC_W-1:0]   out_pc,
  output logic [LANES*PC_W-1:0]   out_npc,
  output logic [LANES*CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]        stall_cnt
);

  // Index 0 is the (kill-adjusted) chain input, index k+1 the output of stage k.
  logic [LANES-1:0]        stg_valid [DEPTH+1];
  logic [LANES*NUM_W-1:0]  stg_num   [DEPTH+1];
  logic [LANES*PC_W-1:0]   stg_pc    [DEPTH+1];
  logic [LANES*PC_W-1:0]   stg_npc   [DEPTH+1];
  logic [LANES*CTRL_W-1:0] stg_ctrl  [DEPTH+1];

  stg_cmd_e         stg_cmd;
  logic [LANES-1:0] kill_valid;
  logic             dup_tag;

  assign stg_cmd = stage_cmd(flush, stop);

  // Wrong-path kill: a taken branch drops every younger lane of its own group.
  always_comb begin
    kill_valid = in_valid;
    if (br_valid) begin
      for (int i = 0; i < LANES; i++) begin
        if (tag_younger(FAB_TAG_MAX_W'(in_num[lane_lsb(i, NUM_W) +: NUM_W]),
                        FAB_TAG_MAX_W'(br_num))) begin
          kill_valid[i] = 1'b0;
        end
      end
    end
  end

  assign stg_valid[0] = kill_valid;
  assign stg_num[0]   = in_num;
  assign stg_pc[0]    = in_pc;
  assign stg_npc[0]   = in_npc;
  assign stg_ctrl[0]  = in_ctrl;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    fab_pipe_stage #(
      .LANES  (LANES),
      .NUM_W  (NUM_W),
      .PC_W   (PC_W),
      .CTRL_W (CTRL_W)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .cmd     (stg_cmd),
      .d_valid (stg_valid[k]),
      .d_num   (stg_num[k]),
      .d_pc    (stg_pc[k]),
      .d_npc   (stg_npc[k]),
      .d_ctrl  (stg_ctrl[k]),
      .q_valid (stg_valid[k+1]),
      .q_num   (stg_num[k+1]),
      .q_pc    (stg_pc[k+1]),
      .q_npc   (stg_npc[k+1]),
      .q_ctrl  (stg_ctrl[k+1])
    );
  end

  assign out_valid = stg_valid[DEPTH];
  assign out_num   = stg_num[DEPTH];
  assign out_pc    = stg_pc[DEPTH];
  assign out_npc   = stg_npc[DEPTH];
  assign out_ctrl  = stg_ctrl[DEPTH];

  // Stall counter: counts only stalls that actually block live output; sticks at max.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stop && !flush && (|out_valid) && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Duplicate order tags among valid lanes break the kill ordering; flag them.
  always_comb begin
    dup_tag = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (in_valid[i] && in_valid[j] &&
            (in_num[lane_lsb(i, NUM_W) +: NUM_W] == in_num[lane_lsb(j, NUM_W) +: NUM_W])) begin
          dup_tag = 1'b1;
        end
      end
    end
  end

  a_no_dup_tag : assert property (@(posedge clk) disable iff (rst)
                                  (!stop && !flush) |-> !dup_tag);

endmodule

// File: tb/tb_fab_pipe_reg.sv
// Bench for fab_pipe_reg: LANES=2, DEPTH=2, CNT_W=4. A reference model keeps
// in-flight groups with the number of advancing edges left before they show
// on the output; each cycle's expected output goes into a queue that an
// independent monitor drains and compares on the falling edge.
module tb_fab_pipe_reg;

  localparam int LANES   = 2;
  localparam int DEPTH   = 2;
  localparam int PC_W    = 32;
  localparam int CTRL_W  = 72;
  localparam int NUM_W   = 1;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                    clk = 1'b0;
  logic                    rst, stop, flush, br_valid;
  logic [LANES-1:0]        in_valid;
  logic [LANES*NUM_W-1:0]  in_num;
  logic [LANES*PC_W-1:0]   in_pc, in_npc;
  logic [LANES*CTRL_W-1:0] in_ctrl;
  logic [NUM_W-1:0]        br_num;
  logic [LANES-1:0]        out_valid;
  logic [LANES*NUM_W-1:0]  out_num;
  logic [LANES*PC_W-1:0]   out_pc, out_npc;
  logic [LANES*CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]        stall_cnt;

  always #5 clk = ~clk;

  fab_pipe_reg #(
    .LANES(LANES), .DEPTH(DEPTH), .PC_W(PC_W), .CTRL_W(CTRL_W),
    .NUM_W(NUM_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .stop(stop), .flush(flush),
    .in_valid(in_valid), .in_num(in_num), .in_pc(in_pc), .in_npc(in_npc),
    .in_ctrl(in_ctrl), .br_valid(br_valid), .br_num(br_num),
    .out_valid(out_valid), .out_num(out_num), .out_pc(out_pc),
    .out_npc(out_npc), .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [LANES-1:0]        v;
    logic [LANES*NUM_W-1:0]  num;
    logic [LANES*PC_W-1:0]   pc;
    logic [LANES*PC_W-1:0]   npc;
    logic [LANES*CTRL_W-1:0] ctrl;
    int                      left;
  } grp_t;

  typedef struct {
    logic [LANES-1:0]        v;
    logic [LANES*NUM_W-1:0]  num;
    logic [LANES*PC_W-1:0]   pc;
    logic [LANES*PC_W-1:0]   npc;
    logic [LANES*CTRL_W-1:0] ctrl;
    logic [CNT_W-1:0]        scnt;
    bit                      zero;
  } exp_t;

  grp_t flight[$];
  exp_t expq[$];
  int   scnt_m = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t model_out();
    exp_t e;
    e = '{v: '0, num: '0, pc: '0, npc: '0, ctrl: '0, scnt: '0, zero: 1'b0};
    if (flight.size() > 0 && flight[0].left == 0) begin
      e.v    = flight[0].v;
      e.num  = flight[0].num;
      e.pc   = flight[0].pc;
      e.npc  = flight[0].npc;
      e.ctrl = flight[0].ctrl;
    end
    return e;
  endfunction

  function automatic logic [LANES*PC_W-1:0] rpc();
    logic [LANES*PC_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*PC_W +: PC_W] = $urandom;
    return r;
  endfunction

  function automatic logic [LANES*CTRL_W-1:0] rctrl();
    logic [LANES*CTRL_W-1:0] r;
    for (int i = 0; i < LANES*CTRL_W; i += 32) r[i +: 32] = $urandom;
    return r;
  endfunction

  // Drive one cycle, then advance the reference model across the same edge.
  task automatic go(input bit r, input bit s, input bit f,
                    input logic [LANES-1:0] v, input logic [LANES*NUM_W-1:0] n,
                    input bit bv, input logic [NUM_W-1:0] bn,
                    input logic [LANES*PC_W-1:0] p);
    exp_t cur, e;
    grp_t g;
    rst = r; stop = s; flush = f; in_valid = v; in_num = n;
    br_valid = bv; br_num = bn; in_pc = p; in_npc = rpc(); in_ctrl = rctrl();
    cur = model_out();
    @(posedge clk);
    if (r) begin
      flight.delete();
      scnt_m = 0;
    end else if (f) begin
      flight.delete();
    end else if (s) begin
      if (cur.v != 0 && scnt_m < CNT_MAX) scnt_m++;
    end else begin
      if (flight.size() > 0 && flight[0].left == 0) void'(flight.pop_front());
      foreach (flight[i]) flight[i].left--;
      g.v = v;
      for (int i = 0; i < LANES; i++)
        if (bv && (n[i*NUM_W +: NUM_W] > bn)) g.v[i] = 1'b0;
      g.num = n; g.pc = p; g.npc = in_npc; g.ctrl = in_ctrl; g.left = DEPTH - 1;
      if (g.v != 0) flight.push_back(g);
    end
    e = model_out();
    e.scnt = CNT_W'(scnt_m);
    e.zero = r;
    expq.push_back(e);
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) go(0, 0, 0, '0, 2'b10, 0, '0, rpc());
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: one expected record per cycle, compared away from the clock edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("out_valid", 128'(out_valid), 128'(e.v));
        chk("stall_cnt", 128'(stall_cnt), 128'(e.scnt));
        for (int i = 0; i < LANES; i++) begin
          if (e.v[i]) begin
            chk($sformatf("num[%0d]", i),  128'(out_num[i*NUM_W +: NUM_W]),  128'(e.num[i*NUM_W +: NUM_W]));
            chk($sformatf("pc[%0d]", i),   128'(out_pc[i*PC_W +: PC_W]),     128'(e.pc[i*PC_W +: PC_W]));
            chk($sformatf("npc[%0d]", i),  128'(out_npc[i*PC_W +: PC_W]),    128'(e.npc[i*PC_W +: PC_W]));
            chk($sformatf("ctrl[%0d]", i), 128'(out_ctrl[i*CTRL_W +: CTRL_W]), 128'(e.ctrl[i*CTRL_W +: CTRL_W]));
          end
        end
        if (e.zero) begin
          chk("reset_pc",   128'(out_pc),   128'(0));
          chk("reset_npc",  128'(out_npc),  128'(0));
          chk("reset_num",  128'(out_num),  128'(0));
          chk("reset_ctrl", 128'(out_ctrl), 128'(0));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; stop = 1'b1; flush = 1'b0; in_valid = 2'b11; in_num = 2'b10;
    br_valid = 1'b0; br_num = '0; in_pc = '0; in_npc = '0; in_ctrl = '0;

    // Reset while stalled with live inputs
    go(1, 1, 0, 2'b11, 2'b10, 0, '0, rpc());
    go(1, 1, 0, 2'b11, 2'b10, 0, '0, rpc());

    // Pass-through, visible for exactly one cycle
    go(0, 0, 0, 2'b11, 2'b10, 0, '0, {32'h104, 32'h100});
    idle(3);

    // Kill: younger lane 1 dropped for br_num=0, kept for br_num=1
    go(0, 0, 0, 2'b11, 2'b10, 1, 1'b0, rpc());
    go(0, 0, 0, 2'b11, 2'b10, 1, 1'b1, rpc());
    go(0, 0, 0, 2'b11, 2'b01, 1, 1'b0, rpc());
    idle(3);

    // Stall three cycles with out_valid=01; inputs during stall are dropped
    go(1, 0, 0, 2'b00, 2'b10, 0, '0, rpc());
    go(0, 0, 0, 2'b01, 2'b10, 0, '0, rpc());
    idle(1);
    for (int i = 0; i < 3; i++) go(0, 1, 0, 2'b11, 2'b10, 0, '0, rpc());
    idle(3);

    // Flush beats stop; counter unchanged
    go(0, 0, 0, 2'b11, 2'b10, 0, '0, rpc());
    go(0, 0, 0, 2'b11, 2'b01, 0, '0, rpc());
    go(0, 1, 1, 2'b11, 2'b10, 0, '0, rpc());
    idle(3);

    // Saturation: 20 stalled cycles with live output
    go(1, 0, 0, 2'b00, 2'b10, 0, '0, rpc());
    go(0, 0, 0, 2'b10, 2'b10, 0, '0, rpc());
    idle(1);
    for (int i = 0; i < 20; i++) go(0, 1, 0, 2'b11, 2'b01, 0, '0, rpc());
    idle(3);

    // Random traffic with stalls, flushes, resets and branches
    for (int i = 0; i < 400; i++) begin
      go($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
         $urandom_range(0, 19) == 0, 2'($urandom_range(0, 3)),
         ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01,
         $urandom_range(0, 1) == 1, 1'($urandom_range(0, 1)), rpc());
    end
    idle(DEPTH + 1);

    for (int i = 0; i < 20 && expq.size() > 0; i++) @(negedge clk);
    if (expq.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout got=%0d want=0 pending", expq.size());
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
